// File: rtl/block_comp_sched_pkg.sv
// Shared types for the block compression scheduler: pixel blocks, core result and FSM states.
package block_comp_sched_pkg;

  localparam int unsigned PIX_PER_BLK = 32;
  localparam int unsigned CHANNELS    = 4;
  localparam int unsigned CH_W        = 8;
  localparam int unsigned BW_W        = 4;

  typedef logic [PIX_PER_BLK-1:0][CHANNELS-1:0][CH_W-1:0] pixels_t;

  typedef struct packed {
    logic [CHANNELS-1:0][CH_W-1:0] min_values;
    logic [CHANNELS-1:0][BW_W-1:0] bit_widths;
  } header_t;

  typedef struct packed {
    header_t header;
    pixels_t residuals;
  } header_residual_reg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/block_comp_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping modulo N.
module block_comp_sched_rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  logic [IW-1:0] pos;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int unsigned off = 0; off < N; off++) begin
      pos = IW'((32'(ptr) + off) % N);
      if (!any && req[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/block_comp_sched.sv
// Shares one block compression core between NUM_REQ requesters: round-robin grant,
// launch, watchdog-guarded wait, and a tagged valid/ready response.
module block_comp_sched
  import block_comp_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  pixels_t                    req_pixels [NUM_REQ],
  output pixels_t                    core_pixels,
  output logic                       core_start,
  input  logic                       core_done,
  input  header_residual_reg         core_hr,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output header_residual_reg         rsp_hr,
  output logic                       rsp_err,
  output logic [CNT_W-1:0]           blocks_done,
  output logic                       busy
);

  localparam int unsigned IW   = $clog2(NUM_REQ);
  localparam int unsigned WD_W = $clog2(TIMEOUT);

  sched_state_e       state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  pixels_t            core_pixels_q, core_pixels_d;
  logic               core_start_q, core_start_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IW-1:0]      rsp_id_q, rsp_id_d;
  header_residual_reg rsp_hr_q, rsp_hr_d;
  logic               rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]   blocks_done_q, blocks_done_d;
  logic [WD_W-1:0]    watchdog_q, watchdog_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic [IW-1:0]      ptr_next_c;

  block_comp_sched_rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign ptr_next_c = IW'((32'(arb_idx) + 32'd1) % NUM_REQ);

  // Accept is offered in the same cycle as the request, and only while idle and out of reset.
  assign req_ready = (rst && (state_q == IDLE)) ? arb_gnt : '0;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    core_pixels_d = core_pixels_q;
    rsp_id_d      = rsp_id_q;
    rsp_hr_d      = rsp_hr_q;
    rsp_err_d     = rsp_err_q;
    blocks_done_d = blocks_done_q;
    watchdog_d    = watchdog_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          core_pixels_d = req_pixels[arb_idx];
          rsp_id_d      = arb_idx;
          rr_ptr_d      = ptr_next_c;
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        watchdog_d = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        watchdog_d = watchdog_q + WD_W'(1);
        // A completion on the expiry cycle still counts as success.
        if (core_done) begin
          rsp_hr_d  = core_hr;
          rsp_err_d = 1'b0;
          state_d   = RESP;
        end else if (watchdog_q == WD_W'(TIMEOUT - 1)) begin
          rsp_hr_d  = '0;
          rsp_err_d = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          blocks_done_d = blocks_done_q + CNT_W'(1);
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    core_start_d = (state_d == ISSUE);
    rsp_valid_d  = (state_d == RESP);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      core_pixels_q <= '0;
      core_start_q  <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_hr_q      <= '0;
      rsp_err_q     <= 1'b0;
      blocks_done_q <= '0;
      watchdog_q    <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      core_pixels_q <= core_pixels_d;
      core_start_q  <= core_start_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_hr_q      <= rsp_hr_d;
      rsp_err_q     <= rsp_err_d;
      blocks_done_q <= blocks_done_d;
      watchdog_q    <= watchdog_d;
      busy_q        <= busy_d;
    end
  end

  assign core_pixels = core_pixels_q;
  assign core_start  = core_start_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_hr      = rsp_hr_q;
  assign rsp_err     = rsp_err_q;
  assign blocks_done = blocks_done_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_block_comp_sched.sv
// Self-checking bench for block_comp_sched: vector table, corner sequences, randomized traffic.
module tb_block_comp_sched;
  import block_comp_sched_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [N-1:0]       req_valid = '0;
  logic [N-1:0]       req_ready;
  pixels_t            req_pixels [N];
  pixels_t            core_pixels;
  logic               core_start;
  logic               core_done;
  header_residual_reg core_hr;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [1:0]         rsp_id;
  header_residual_reg rsp_hr;
  logic               rsp_err;
  logic [CW-1:0]      blocks_done;
  logic               busy;

  int total = 0;
  int bad   = 0;
  int exp_blocks = 0;

  block_comp_sched #(.NUM_REQ(N), .TIMEOUT(64), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_pixels(req_pixels), .core_pixels(core_pixels), .core_start(core_start),
    .core_done(core_done), .core_hr(core_hr), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_hr(rsp_hr), .rsp_err(rsp_err),
    .blocks_done(blocks_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference compressor: per-channel minimum, residual from it, bits needed for the largest residual.
  function automatic header_residual_reg ref_hr(input pixels_t p);
    header_residual_reg r;
    int mn, mx, bw;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      mn = 255;
      mx = 0;
      for (int i = 0; i < 32; i++) if (int'(p[i][c]) < mn) mn = int'(p[i][c]);
      for (int i = 0; i < 32; i++) begin
        r.residuals[i][c] = p[i][c] - 8'(mn);
        if (int'(p[i][c]) - mn > mx) mx = int'(p[i][c]) - mn;
      end
      bw = 0;
      while ((mx >> bw) != 0) bw++;
      r.header.min_values[c] = 8'(mn);
      r.header.bit_widths[c] = 4'(bw);
    end
    return r;
  endfunction

  function automatic pixels_t rand_pix();
    pixels_t p;
    for (int i = 0; i < 32; i++)
      for (int c = 0; c < 4; c++) p[i][c] = 8'($urandom_range(0, 255));
    return p;
  endfunction

  function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
    for (int off = 0; off < int'(N); off++) begin
      if (v[(ptr + off) % N]) return (ptr + off) % N;
    end
    return -1;
  endfunction

  // Core model: answers core_lat cycles after core_start (0 = never); plus a manual injection path.
  int                 core_lat = 2;
  int                 core_cnt = 0;
  logic               model_done = 1'b0;
  header_residual_reg model_hr = '0;
  logic               inj_done = 1'b0;
  header_residual_reg inj_hr = '0;

  assign core_done = model_done | inj_done;
  assign core_hr   = inj_done ? inj_hr : model_hr;

  always @(posedge clk) begin
    #1;
    model_done = 1'b0;
    if (!rst) core_cnt = 0;
    else begin
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          model_done = 1'b1;
          model_hr   = ref_hr(core_pixels);
        end
      end
      if (core_start) core_cnt = core_lat;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_hr(input string nm, input header_residual_reg act, input header_residual_reg exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got header %h expected header %h (residuals %s)", nm,
               act.header, exp.header, (act.residuals === exp.residuals) ? "equal" : "differ");
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    inj_done = 1'b0;
    core_lat = 2;
    tick();
    tick();
    rst = 1'b1;
    exp_blocks = 0;
    tick();
  endtask

  // Present fresh blocks on mask and wait for the accept; leaves the DUT in ISSUE.
  task automatic grant_wait(input logic [N-1:0] mask, output int gid, output header_residual_reg ehr);
    gid = -1;
    ehr = '0;
    for (int i = 0; i < int'(N); i++) req_pixels[i] = rand_pix();
    req_valid = mask;
    for (int c = 0; c < 50 && gid < 0; c++) begin
      #1;
      if (req_ready != '0) begin
        for (int i = 0; i < int'(N); i++) if (req_ready[i]) gid = i;
        chk("grant_onehot", 64'($countones(req_ready)), 1);
        ehr = ref_hr(req_pixels[gid]);
      end
      tick();
    end
    req_valid = '0;
    if (gid < 0) begin
      total++;
      bad++;
      $display("FAIL grant_wait: no accept within 50 cycles");
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      if (rsp_valid) ok = 1'b1;
      else tick();
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL wait_rsp: no response within 200 cycles");
    end
  endtask

  task automatic finish_rsp(input string tag, input int eid, input bit eerr, input header_residual_reg ehr);
    bit ok;
    rsp_ready = 1'b1;
    wait_rsp(ok);
    if (ok) begin
      chk({tag, "_id"}, 64'(rsp_id), 64'(eid));
      chk({tag, "_err"}, 64'(rsp_err), 64'(eerr));
      chk_hr({tag, "_hr"}, rsp_hr, ehr);
      tick();
      exp_blocks++;
      chk({tag, "_cnt"}, 64'(blocks_done), 64'(exp_blocks));
      chk({tag, "_drop"}, 64'(rsp_valid), 0);
    end
  endtask

  typedef struct {
    bit           rst_first;
    logic [N-1:0] mask;
    int           lat;
    int           exp_id;
  } vec_t;

  typedef struct {
    int                 id;
    header_residual_reg hr;
  } exp_t;

  vec_t tbl [14];

  initial begin : main
    int gid, n, mptr, w;
    header_residual_reg ehr, zero_hr;
    logic [N-1:0] pend, exp_rdy;
    pixels_t ppix [N];
    exp_t q[$];
    exp_t e;
    bit inflight, allow, got_g, got_r, ok;

    zero_hr = '0;
    tbl[0]  = '{1'b1, 4'b0001, 2, 0};
    tbl[1]  = '{1'b1, 4'b1111, 2, 0};
    tbl[2]  = '{1'b0, 4'b1111, 1, 1};
    tbl[3]  = '{1'b0, 4'b1111, 3, 2};
    tbl[4]  = '{1'b0, 4'b1111, 2, 3};
    tbl[5]  = '{1'b0, 4'b1111, 1, 0};
    tbl[6]  = '{1'b0, 4'b1111, 2, 1};
    tbl[7]  = '{1'b0, 4'b1111, 4, 2};
    tbl[8]  = '{1'b0, 4'b1111, 2, 3};
    tbl[9]  = '{1'b1, 4'b0010, 2, 1};
    tbl[10] = '{1'b0, 4'b1011, 2, 3};
    tbl[11] = '{1'b0, 4'b1011, 1, 0};
    tbl[12] = '{1'b0, 4'b1011, 3, 1};
    tbl[13] = '{1'b0, 4'b0100, 2, 2};

    // Reset values, with requests pending to show accepts are held off.
    for (int i = 0; i < int'(N); i++) req_pixels[i] = rand_pix();
    req_valid = 4'b1111;
    #12;
    chk("rst_ready", 64'(req_ready), 0);
    chk("rst_start", 64'(core_start), 0);
    chk("rst_pix", 64'(core_pixels != '0), 0);
    chk("rst_valid", 64'(rsp_valid), 0);
    chk("rst_id", 64'(rsp_id), 0);
    chk_hr("rst_hr", rsp_hr, zero_hr);
    chk("rst_err", 64'(rsp_err), 0);
    chk("rst_cnt", 64'(blocks_done), 0);
    chk("rst_busy", 64'(busy), 0);

    // Table: single requester, round-robin order, fairness from rr_ptr=2.
    for (int k = 0; k < 14; k++) begin
      if (tbl[k].rst_first) do_reset();
      core_lat = tbl[k].lat;
      rsp_ready = 1'b1;
      grant_wait(tbl[k].mask, gid, ehr);
      chk($sformatf("tbl%0d_grant", k), 64'(gid), 64'(tbl[k].exp_id));
      finish_rsp($sformatf("tbl%0d", k), tbl[k].exp_id, 1'b0, ehr);
    end

    // Backpressure: response held for 10 cycles while other requests wait.
    core_lat = 1;
    rsp_ready = 1'b0;
    grant_wait(4'b1000, gid, ehr);
    chk("bp_grant", 64'(gid), 3);
    wait_rsp(ok);
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < int'(N); i++) req_pixels[i] = rand_pix();
      req_valid = 4'b1111;
      #1;
      chk("bp_valid", 64'(rsp_valid), 1);
      chk("bp_id", 64'(rsp_id), 3);
      chk_hr("bp_hr", rsp_hr, ehr);
      chk("bp_ready", 64'(req_ready), 0);
      chk("bp_start", 64'(core_start), 0);
      chk("bp_cnt", 64'(blocks_done), 64'(exp_blocks));
      tick();
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    tick();
    exp_blocks++;
    chk("bp_cnt_inc", 64'(blocks_done), 64'(exp_blocks));
    chk("bp_drop", 64'(rsp_valid), 0);

    // Watchdog expiry with a silent core.
    core_lat = 0;
    grant_wait(4'b0001, gid, ehr);
    chk("to_issue_start", 64'(core_start), 1);
    tick();
    n = 1;
    chk("to_start_pulse", 64'(core_start), 0);
    while (!rsp_valid && n < 200) begin
      tick();
      n++;
    end
    chk("to_cycles", 64'(n - 1), 64);
    chk("to_valid", 64'(rsp_valid), 1);
    chk("to_id", 64'(rsp_id), 0);
    chk("to_err", 64'(rsp_err), 1);
    chk_hr("to_hr", rsp_hr, zero_hr);
    tick();
    exp_blocks++;
    chk("to_cnt", 64'(blocks_done), 64'(exp_blocks));

    // Completion arriving on the expiry cycle beats the timeout.
    rsp_ready = 1'b0;
    grant_wait(4'b0001, gid, ehr);
    for (n = 0; n < 64; n++) tick();
    chk("exp_not_early", 64'(rsp_valid), 0);
    inj_hr = ref_hr(rand_pix());
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    chk("exp_valid", 64'(rsp_valid), 1);
    chk("exp_err", 64'(rsp_err), 0);
    chk_hr("exp_hr", rsp_hr, inj_hr);
    rsp_ready = 1'b1;
    tick();
    exp_blocks++;
    chk("exp_cnt", 64'(blocks_done), 64'(exp_blocks));

    // Reset in the middle of WAIT, then a stale core_done.
    grant_wait(4'b0010, gid, ehr);
    chk("rw_grant", 64'(gid), 1);
    for (int c = 0; c < 5; c++) tick();
    req_valid = 4'b1111;
    rst = 1'b0;
    #1;
    chk("rw_busy", 64'(busy), 0);
    chk("rw_ready", 64'(req_ready), 0);
    chk("rw_pix", 64'(core_pixels != '0), 0);
    chk("rw_start", 64'(core_start), 0);
    chk("rw_valid", 64'(rsp_valid), 0);
    chk("rw_cnt", 64'(blocks_done), 0);
    tick();
    req_valid = '0;
    rst = 1'b1;
    exp_blocks = 0;
    tick();
    inj_hr = ref_hr(rand_pix());
    inj_done = 1'b1;
    tick();
    inj_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rw_late_valid", 64'(rsp_valid), 0);
      chk("rw_late_busy", 64'(busy), 0);
      tick();
    end
    core_lat = 2;
    grant_wait(4'b1111, gid, ehr);
    chk("rw_regrant", 64'(gid), 0);
    finish_rsp("rw", 0, 1'b0, ehr);

    // Randomized traffic against the round-robin reference.
    do_reset();
    mptr = 0;
    pend = '0;
    inflight = 1'b0;
    q.delete();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      allow = (cyc < 2500);
      if (!allow && !inflight && pend == '0 && q.size() == 0) break;
      if (allow) begin
        for (int i = 0; i < int'(N); i++) begin
          if (!pend[i] && $urandom_range(0, 3) == 0) begin
            pend[i] = 1'b1;
            ppix[i] = rand_pix();
          end
        end
      end
      req_valid = pend;
      for (int i = 0; i < int'(N); i++) req_pixels[i] = ppix[i];
      rsp_ready = 1'($urandom_range(0, 1));
      if (!inflight) core_lat = $urandom_range(1, 4);
      #1;
      w = rr_pick(mptr, pend);
      exp_rdy = '0;
      if (!inflight && w >= 0) exp_rdy[w] = 1'b1;
      chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));
      got_g = (exp_rdy != '0);
      if (got_g) begin
        e.id = w;
        e.hr = ref_hr(ppix[w]);
        q.push_back(e);
        mptr = (w + 1) % N;
      end
      got_r = rsp_valid && rsp_ready;
      if (got_r) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rnd_extra: response id %0d with nothing outstanding", rsp_id);
        end else begin
          e = q.pop_front();
          chk("rnd_id", 64'(rsp_id), 64'(e.id));
          chk("rnd_err", 64'(rsp_err), 0);
          chk_hr("rnd_hr", rsp_hr, e.hr);
        end
      end
      tick();
      if (got_g) begin
        pend[w] = 1'b0;
        inflight = 1'b1;
      end
      if (got_r) begin
        inflight = 1'b0;
        exp_blocks++;
        chk("rnd_cnt", 64'(blocks_done), 64'(exp_blocks));
      end
    end
    chk("rnd_drain", 64'(q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : guard
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/block_comp_sched.md
Name: block_comp_sched

Overview:
- Scheduler and arbiter that shares one pixel-block compression core (32 RGBA pixels in, header plus residuals out) between NUM_REQ requesters.
- Picks a requester round-robin, latches its 32-pixel block and launches the core.
- Waits for the core to finish, with a watchdog, then returns the header_residual_reg result tagged with the requester id over a valid/ready response channel.
- Sits between the frame-tile fetchers and the compressor core in the send path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles in WAIT before an error response (>= 2).
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- req_valid  in  NUM_REQ  per-requester block-available flag
- req_ready  out  NUM_REQ  one-hot accept; transfer occurs when req_valid[i] && req_ready[i]
- req_pixels  in  NUM_REQ x types::pixels_t  per-requester 32x4x8-bit block
- core_pixels  out  types::pixels_t  latched block driven to the core
- core_start  out  1  one-cycle launch pulse
- core_done  in  1  one-cycle completion pulse from the core
- core_hr  in  types::header_residual_reg  core result, valid while core_done=1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accept
- rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns the response
- rsp_hr  out  types::header_residual_reg  result
- rsp_err  out  1  1 = watchdog timeout; rsp_hr is zero
- blocks_done  out  CNT_W  count of responses accepted; wraps modulo 2^CNT_W
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, rr_ptr=0, req_ready=0, core_start=0, core_pixels=0, rsp_valid=0, rsp_id=0, rsp_hr=0, rsp_err=0, blocks_done=0, watchdog=0.
- Reset mid-operation abandons any block in flight. No response is produced for it. A late core_done after reset is ignored.
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - The winner is the first i with req_valid[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle; all other bits are 0.
  - On that edge: latch req_pixels[winner] into core_pixels, latch id=winner, set rr_ptr=(winner+1) mod NUM_REQ, go to ISSUE.
  - If no req_valid is set, stay in IDLE and leave rr_ptr unchanged.
- ISSUE: core_start=1 for exactly this cycle, clear the watchdog, go to WAIT unconditionally. core_pixels is held stable from ISSUE through the end of WAIT.
- WAIT:
  - Watchdog increments each cycle.
  - On core_done=1: capture core_hr into rsp_hr, rsp_err=0, go to RESP.
  - Else if watchdog reaches TIMEOUT-1: rsp_hr=0, rsp_err=1, go to RESP.
  - If core_done and timeout occur in the same cycle, core_done wins.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_hr and rsp_err held stable until rsp_ready=1.
  - On the handshake edge: blocks_done += 1 (error responses included), rsp_valid drops, go to IDLE.
- req_ready is 0 in every state except IDLE.
- core_done outside WAIT is ignored.
- Only one block is outstanding at a time.
- Minimum cycles per block is 3 + core latency. Given IDLE grant, ISSUE, at least one WAIT cycle, RESP with rsp_ready=1, the minimum grant-to-grant spacing is 4 cycles when core_done arrives in the first WAIT cycle.
- Requesters must hold req_valid and req_pixels until accepted. The scheduler samples them only on the accept cycle.
- Fairness: a requester that is continuously valid is granted within NUM_REQ grants.

Decomposition:
- Package types: pixels_t and header_residual_reg (existing).
- Add to types: sched_state_e (IDLE, ISSUE, WAIT, RESP).
- The parameterised rr_ptr and id width derive from $clog2(NUM_REQ) locally.
- One sub-module: rr_arbiter (req vector and pointer in, one-hot grant and encoded index out, combinational).

Test Plan:
- Single requester: req_valid=4'b0001 with a random block; core model returns core_done 2 cycles after core_start, with per-channel minima. Required: rsp_id=0, rsp_err=0, rsp_hr.header.min_values matches the reference minima, blocks_done=1.
- Round-robin: req_valid=4'b1111 held, 8 blocks. Required: grant order 0,1,2,3,0,1,2,3, and each rsp_id matches.
- Fairness: from rr_ptr=2, req_valid=4'b1011. Required: grant order 3,0,1.
- Backpressure: rsp_ready=0 for 10 cycles in RESP. Required: rsp_valid and data stable, req_ready all 0, no core_start. With rsp_ready=1: one increment of blocks_done.
- Timeout: core never asserts done, TIMEOUT=64. Required: rsp_valid with rsp_err=1, rsp_hr=0, reached 64 cycles after the WAIT entry edge. A core_done injected on the expiry cycle gives rsp_err=0.
- Reset mid-WAIT: drop rst for 1 cycle. Required: all outputs 0 immediately (asynchronous). A subsequent core_done is ignored, and the next grant starts from requester 0.
